// File: rtl/fetch_pc_unit_pkg.sv
// fetch_pkg: shared types and instruction field positions for the fetch/PC stage.
package fetch_pkg;

    localparam int INSTR_W  = 32;

    // Instruction field slices (MIPS-style encoding)
    localparam int OP_MSB   = 31;
    localparam int OP_LSB   = 26;
    localparam int IMM_MSB  = 15;
    localparam int IMM_LSB  = 0;
    localparam int JIDX_MSB = 25;
    localparam int JIDX_LSB = 0;
    localparam int JIDX_W   = JIDX_MSB - JIDX_LSB + 1;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_unit_next_pc.sv
// next_pc_logic: purely combinational next-PC selection (jump > taken branch > pc+4).
// All arithmetic wraps modulo 2^PC_W.
module next_pc_logic
    import fetch_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic [PC_W-1:0]   pc,
    input  logic [JIDX_W-1:0] jidx,      // instr[25:0]; low 16 bits are the branch immediate
    input  logic              jump,
    input  logic              branch,
    input  logic              bne,
    input  logic              zero,
    output logic [PC_W-1:0]   next_pc,
    output logic              redirect   // jump or taken branch
);

    logic [PC_W-1:0] pc4;
    logic [15:0]     imm;
    logic            taken;

    assign pc4   = pc + PC_W'(3'd4);
    assign imm   = jidx[IMM_MSB:IMM_LSB];
    assign taken = (branch & zero) | (bne & ~zero);

    // Jump has absolute priority, then a resolved branch, else fall through.
    always_comb begin
        next_pc = pc4;
        if (jump)
            next_pc = PC_W'({jidx, 2'b00});
        else if (taken)
            next_pc = pc4 + PC_W'({{14{imm[15]}}, imm, 2'b00});
    end

    assign redirect = jump | taken;

endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: holds the PC, fetches one instruction over req/gnt/rvalid,
// presents it to the decoder and advances the PC once execute completes.
// Optional retire/redirect counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]        retired_cnt,
    output logic [31:0]        taken_cnt,
`endif
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic [PC_W-1:0]    pc,
    input  logic               exec_done,
    input  logic               jump,
    input  logic               branch,
    input  logic               bne,
    input  logic               zero
);

    fetch_state_t    state, state_nxt;
    logic [PC_W-1:0] next_pc;
    logic            redirect;
    logic            load_instr;
    logic            retire;

    assign load_instr = (state == WAIT)  && imem_rvalid;
    assign retire     = (state == ISSUE) && exec_done;
    assign imem_addr  = pc;

    next_pc_logic #(.PC_W(PC_W)) u_next_pc (
        .pc       (pc),
        .jidx     (instr[JIDX_MSB:JIDX_LSB]),
        .jump     (jump),
        .branch   (branch),
        .bne      (bne),
        .zero     (zero),
        .next_pc  (next_pc),
        .redirect (redirect)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= FETCH;
        else        state <= state_nxt;
    end

    // Next-state and request; req is masked during reset so it first rises after release
    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        case (state)
            FETCH: begin
                imem_req = rst_n;
                if (imem_gnt) state_nxt = WAIT;
            end
            WAIT:    if (imem_rvalid) state_nxt = ISSUE;
            ISSUE:   if (exec_done)   state_nxt = FETCH;
            default: state_nxt = FETCH;
        endcase
    end

    // PC and instruction holding registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
        end else begin
            if (load_instr) begin
                instr       <= imem_rdata;
                instr_valid <= 1'b1;
            end
            if (retire) begin
                pc          <= next_pc;
                instr_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Retired-instruction and redirect counters, free-running with 32-bit wrap
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retired_cnt <= '0;
            taken_cnt   <= '0;
        end else if (retire) begin
            retired_cnt <= retired_cnt + 32'd1;
            if (redirect) taken_cnt <= taken_cnt + 32'd1;
        end
    end
`else
    logic unused_redirect;
    assign unused_redirect = redirect;
`endif

endmodule
